// File: rtl/pipe_ctrl_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_unit_if : D-stage inputs and E/W control outputs          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pipe_ctrl_unit_if;
  logic [31:0] inst_d;
  logic        valid_d;
  logic        br_taken_e;
  logic [2:0]  imm_src_d;
  logic        stall_fd;
  logic        pcsrc;
  logic        reg_wr_e;
  logic        sel_a_e;
  logic        sel_b_e;
  logic        btype_e;
  logic        csr_wr_e;
  logic        csr_rd_e;
  logic        illegal_e;
  logic [1:0]  wb_sel_e;
  logic [4:0]  alu_op_e;
  logic [2:0]  funct3_e;
  logic [4:0]  rd_e;
  logic        reg_wr_w;
  logic [1:0]  wb_sel_w;
  logic [4:0]  rd_w;
  logic        md_busy;

  modport master (
    output inst_d, valid_d, br_taken_e,
    input  imm_src_d, stall_fd, pcsrc, reg_wr_e, sel_a_e, sel_b_e, btype_e,
           csr_wr_e, csr_rd_e, illegal_e, wb_sel_e, alu_op_e, funct3_e, rd_e,
           reg_wr_w, wb_sel_w, rd_w, md_busy
  );

  modport slave (
    input  inst_d, valid_d, br_taken_e,
    output imm_src_d, stall_fd, pcsrc, reg_wr_e, sel_a_e, sel_b_e, btype_e,
           csr_wr_e, csr_rd_e, illegal_e, wb_sel_e, alu_op_e, funct3_e, rd_e,
           reg_wr_w, wb_sel_w, rd_w, md_busy
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_unit : RV32I(M) decode, E/W control registers, hazards    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipe_ctrl_unit #(
  parameter int unsigned M_EXT     = 1,
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CSR_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_unit_if.slave  bus
);

  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       reg_wr;
    logic       sel_a;
    logic       sel_b;
    logic       btype;
    logic       csr_wr;
    logic       csr_rd;
    logic       illegal;
    logic [1:0] wb_sel;
    logic [4:0] alu_op;
    logic [2:0] funct3;
    logic [4:0] rd;
  } ctrl_t;

  typedef struct packed {
    logic       reg_wr;
    logic [1:0] wb_sel;
    logic [4:0] rd;
  } wctrl_t;

  typedef enum logic [0:0] {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         e_q, e_d;
  wctrl_t        w_q, w_d;

  ctrl_t       dec;
  logic [2:0]  imm_src;
  logic        uses_rs1, uses_rs2, legal;
  logic        loaduse, pcsrc, e_is_md, stall, md_busy;

  wire [6:0] opc = bus.inst_d[6:0];
  wire [2:0] f3  = bus.inst_d[14:12];
  wire [6:0] f7  = bus.inst_d[31:25];
  wire [4:0] rs1 = bus.inst_d[19:15];
  wire [4:0] rs2 = bus.inst_d[24:20];

  // alt selects SUB/SRA encodings (funct7 = 0100000)
  function automatic logic [4:0] base_alu(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  base_alu = alt ? 5'd1 : 5'd0;
      3'b001:  base_alu = 5'd2;
      3'b010:  base_alu = 5'd3;
      3'b011:  base_alu = 5'd4;
      3'b100:  base_alu = 5'd5;
      3'b101:  base_alu = alt ? 5'd7 : 5'd6;
      3'b110:  base_alu = 5'd8;
      default: base_alu = 5'd9;
    endcase
  endfunction

  always_comb begin
    dec        = '0;
    dec.funct3 = f3;
    dec.rd     = bus.inst_d[11:7];
    dec.sel_a  = 1'b1;
    imm_src    = 3'b000;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    legal      = 1'b1;
    case (opc)
      OP_RTYPE: begin
        uses_rs1 = 1'b1;  uses_rs2 = 1'b1;
        dec.reg_wr = 1'b1; dec.wb_sel = 2'b01;
        if (f7 == 7'b0000000)
          dec.alu_op = base_alu(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          dec.alu_op = base_alu(f3, 1'b1);
        else if (f7 == 7'b0000001 && M_EXT != 0)
          dec.alu_op = 5'd11 + {2'b00, f3};
        else
          legal = 1'b0;
      end
      OP_IMM: begin
        uses_rs1 = 1'b1;
        dec.reg_wr = 1'b1; dec.wb_sel = 2'b01; dec.sel_b = 1'b1;
        if (f3 == 3'b001)
          legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101)
          legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        dec.alu_op = base_alu(f3, (f3 == 3'b101) && f7[5]);
      end
      OP_LOAD: begin
        uses_rs1 = 1'b1;
        dec.reg_wr = 1'b1; dec.wb_sel = 2'b10; dec.sel_b = 1'b1;
      end
      OP_STORE: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.sel_b = 1'b1; imm_src = 3'b001;
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.btype = 1'b1; dec.sel_a = 1'b0; dec.sel_b = 1'b1; imm_src = 3'b010;
      end
      OP_JAL: begin
        dec.btype = 1'b1; dec.reg_wr = 1'b1; dec.sel_a = 1'b0; dec.sel_b = 1'b1;
        imm_src = 3'b011;
      end
      OP_JALR: begin
        uses_rs1 = 1'b1;
        dec.btype = 1'b1; dec.reg_wr = 1'b1; dec.sel_b = 1'b1;
      end
      OP_LUI: begin
        dec.reg_wr = 1'b1; dec.wb_sel = 2'b01; dec.sel_b = 1'b1;
        dec.alu_op = 5'd10; imm_src = 3'b100;
      end
      OP_AUIPC: begin
        dec.reg_wr = 1'b1; dec.wb_sel = 2'b01; dec.sel_a = 1'b0; dec.sel_b = 1'b1;
        imm_src = 3'b100;
      end
      OP_FENCE: ;
      OP_SYSTEM: begin
        if (f3 == 3'b000) begin
          // ECALL/EBREAK pass through as a no-write bundle
        end else if (CSR_EN != 0 && f3 != 3'b100) begin
          uses_rs1 = 1'b1;
          dec.reg_wr = 1'b1; dec.wb_sel = 2'b11; dec.csr_rd = 1'b1;
          dec.csr_wr = (f3[1:0] == 2'b01) || (rs1 != 5'd0);
          dec.sel_b  = f3[2];
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign pcsrc   = e_q.btype & bus.br_taken_e;
  assign e_is_md = (e_q.alu_op >= 5'd11);
  assign loaduse = bus.valid_d & e_q.reg_wr & (e_q.wb_sel == 2'b10) & (e_q.rd != 5'd0) &
                   ((uses_rs1 & (rs1 == e_q.rd)) | (uses_rs2 & (rs2 == e_q.rd)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    w_d     = '{reg_wr: e_q.reg_wr, wb_sel: e_q.wb_sel, rd: e_q.rd};
    stall   = 1'b0;
    md_busy = 1'b0;
    case (state_q)
      RUN: begin
        if (pcsrc) begin
          e_d = '0;
        end else if (e_is_md && MD_CYCLES > 1) begin
          state_d = MD_WAIT;
          cnt_d   = CW'(MD_CYCLES - 1);
          md_busy = 1'b1;
          stall   = 1'b1;
          w_d     = '0;
        end else if (loaduse) begin
          e_d   = '0;
          stall = 1'b1;
        end else begin
          e_d = bus.valid_d ? dec : '0;
        end
      end
      MD_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        // Last occupancy cycle: the M op retires to W and D advances
        if (cnt_q == CW'(1)) begin
          state_d = RUN;
          e_d     = bus.valid_d ? dec : '0;
        end else begin
          md_busy = 1'b1;
          stall   = 1'b1;
          w_d     = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      e_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      w_q     <= w_d;
    end
  end

  assign bus.imm_src_d = imm_src;
  assign bus.stall_fd  = stall;
  assign bus.pcsrc     = pcsrc;
  assign bus.md_busy   = md_busy;
  assign bus.reg_wr_e  = e_q.reg_wr;
  assign bus.sel_a_e   = e_q.sel_a;
  assign bus.sel_b_e   = e_q.sel_b;
  assign bus.btype_e   = e_q.btype;
  assign bus.csr_wr_e  = e_q.csr_wr;
  assign bus.csr_rd_e  = e_q.csr_rd;
  assign bus.illegal_e = e_q.illegal;
  assign bus.wb_sel_e  = e_q.wb_sel;
  assign bus.alu_op_e  = e_q.alu_op;
  assign bus.funct3_e  = e_q.funct3;
  assign bus.rd_e      = e_q.rd;
  assign bus.reg_wr_w  = w_q.reg_wr;
  assign bus.wb_sel_w  = w_q.wb_sel;
  assign bus.rd_w      = w_q.rd;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_ctrl_unit : directed vectors with queued expectations       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pipe_ctrl_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_unit_if if0 ();
  pipe_ctrl_unit_if if1 ();

  assign if1.inst_d     = if0.inst_d;
  assign if1.valid_d    = if0.valid_d;
  assign if1.br_taken_e = if0.br_taken_e;

  pipe_ctrl_unit #(.M_EXT(1), .MD_CYCLES(4), .CSR_EN(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  pipe_ctrl_unit #(.M_EXT(0), .MD_CYCLES(4), .CSR_EN(1)) u_dut_nom (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  localparam logic [31:0] ADD3  = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] ADDI4 = 32'h0051_8213; // addi x4,x3,5
  localparam logic [31:0] LW5   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD6  = 32'h0022_8333; // add  x6,x5,x2
  localparam logic [31:0] BEQ   = 32'h0020_8463; // beq  x1,x2,+8
  localparam logic [31:0] DIV7  = 32'h0220_C3B3; // div  x7,x1,x2
  localparam logic [31:0] MUL8  = 32'h0220_8433; // mul  x8,x1,x2
  localparam logic [31:0] BAD   = 32'h0000_007F;
  localparam logic [31:0] CSR9  = 32'h3000_94F3; // csrrw x9,0x300,x1
  localparam logic [31:0] SUB10 = 32'h4020_8533; // sub  x10,x1,x2

  typedef struct {
    int         idx;
    logic       st, pc, mb, rwe;
    logic [1:0] wbe;
    logic [4:0] alu, rde;
    logic       ill, cwe, rww;
    logic [4:0] rdw;
    logic       chk_nom;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;
  bit   done  = 1'b0;

  task automatic chk(input string name, input int idx, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL c%0d %s: got %0d expected %0d", idx, name, act, req);
    end
  endtask

  task automatic v(input logic r, input logic [31:0] inst, input logic vld, input logic br,
                   input logic st, input logic pc, input logic mb, input logic rwe,
                   input int wbe, input int alu, input int rde,
                   input logic ill, input logic cwe, input logic rww, input int rdw,
                   input logic cn);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    if0.inst_d     = inst;
    if0.valid_d    = vld;
    if0.br_taken_e = br;
    e.idx = vec; e.st = st; e.pc = pc; e.mb = mb; e.rwe = rwe;
    e.wbe = 2'(wbe); e.alu = 5'(alu); e.rde = 5'(rde);
    e.ill = ill; e.cwe = cwe; e.rww = rww; e.rdw = 5'(rdw); e.chk_nom = cn;
    q.push_back(e);
    vec++;
  endtask

  // Monitor: the unit presents a full output set every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_fd",  e.idx, int'(if0.stall_fd),  int'(e.st));
        chk("pcsrc",     e.idx, int'(if0.pcsrc),     int'(e.pc));
        chk("md_busy",   e.idx, int'(if0.md_busy),   int'(e.mb));
        chk("reg_wr_e",  e.idx, int'(if0.reg_wr_e),  int'(e.rwe));
        chk("wb_sel_e",  e.idx, int'(if0.wb_sel_e),  int'(e.wbe));
        chk("alu_op_e",  e.idx, int'(if0.alu_op_e),  int'(e.alu));
        chk("rd_e",      e.idx, int'(if0.rd_e),      int'(e.rde));
        chk("illegal_e", e.idx, int'(if0.illegal_e), int'(e.ill));
        chk("csr_wr_e",  e.idx, int'(if0.csr_wr_e),  int'(e.cwe));
        chk("reg_wr_w",  e.idx, int'(if0.reg_wr_w),  int'(e.rww));
        chk("rd_w",      e.idx, int'(if0.rd_w),      int'(e.rdw));
        if (e.chk_nom) begin
          chk("nom.illegal_e", e.idx, int'(if1.illegal_e), 1);
          chk("nom.reg_wr_e",  e.idx, int'(if1.reg_wr_e),  0);
          chk("nom.csr_wr_e",  e.idx, int'(if1.csr_wr_e),  0);
        end
      end
    end
  end

  initial begin
    repeat (2000) @(posedge clk);
    if (!done) begin
      bad++;
      $display("FAIL timeout: got running expected finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    if0.inst_d     = 32'h0;
    if0.valid_d    = 1'b0;
    if0.br_taken_e = 1'b0;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    //  rst inst   vld br  st pc mb rwe wbe alu rde ill cwe rww rdw nom
    v(0, 32'h0,  0, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    v(0, ADD3,   1, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    v(0, ADDI4,  1, 0,  0, 0, 0, 1,  1,  0,  3,  0,  0,  0,  0,  0);
    v(0, 32'h0,  0, 0,  0, 0, 0, 1,  1,  0,  4,  0,  0,  1,  3,  0);
    // load-use: one stall cycle, one bubble
    v(0, LW5,    1, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  1,  4,  0);
    v(0, ADD6,   1, 0,  1, 0, 0, 1,  2,  0,  5,  0,  0,  0,  0,  0);
    v(0, ADD6,   1, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  1,  5,  0);
    v(0, BEQ,    1, 0,  0, 0, 0, 1,  1,  0,  6,  0,  0,  0,  0,  0);
    // taken branch flushes the D instruction
    v(0, ADDI4,  1, 1,  0, 1, 0, 0,  0,  0,  8,  0,  0,  1,  6,  0);
    v(0, 32'h0,  0, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  8,  0);
    // div occupies E for four cycles
    v(0, DIV7,   1, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    v(0, ADD3,   1, 0,  1, 0, 1, 1,  1, 15,  7,  0,  0,  0,  0,  0);
    v(0, ADD3,   1, 0,  1, 0, 1, 1,  1, 15,  7,  0,  0,  0,  0,  0);
    v(0, ADD3,   1, 0,  1, 0, 1, 1,  1, 15,  7,  0,  0,  0,  0,  0);
    v(0, ADD3,   1, 0,  0, 0, 0, 1,  1, 15,  7,  0,  0,  0,  0,  0);
    v(0, 32'h0,  0, 0,  0, 0, 0, 1,  1,  0,  3,  0,  0,  1,  7,  0);
    // mul: M op here, illegal in the no-M instance
    v(0, MUL8,   1, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  1,  3,  0);
    v(0, BAD,    1, 0,  1, 0, 1, 1,  1, 11,  8,  0,  0,  0,  0,  1);
    v(0, BAD,    1, 0,  1, 0, 1, 1,  1, 11,  8,  0,  0,  0,  0,  0);
    v(0, BAD,    1, 0,  1, 0, 1, 1,  1, 11,  8,  0,  0,  0,  0,  0);
    v(0, BAD,    1, 0,  0, 0, 0, 1,  1, 11,  8,  0,  0,  0,  0,  0);
    v(0, CSR9,   1, 0,  0, 0, 0, 0,  0,  0,  0,  1,  0,  1,  8,  0);
    v(0, SUB10,  1, 0,  0, 0, 0, 1,  3,  0,  9,  0,  1,  0,  0,  0);
    v(0, DIV7,   1, 0,  0, 0, 0, 1,  1,  1, 10,  0,  0,  1,  9,  0);
    // reset on the second MD_WAIT cycle aborts the div
    v(0, ADD3,   1, 0,  1, 0, 1, 1,  1, 15,  7,  0,  0,  1, 10,  0);
    v(0, ADD3,   1, 0,  1, 0, 1, 1,  1, 15,  7,  0,  0,  0,  0,  0);
    v(1, ADD3,   1, 0,  1, 0, 1, 1,  1, 15,  7,  0,  0,  0,  0,  0);
    v(0, 32'h0,  0, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    v(0, 32'h0,  0, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0);
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
